// File: rtl/fetch_sequencer.sv
// fetch_sequencer: imem fetch front end; resolves JMP/JNZ/ZNJ locally, issues other ops to execute, detects halt
// Ports: clk/rst_n clock and async active-low reset; start_i leaves IDLE; pc_o/op_i imem address and data;
// dec_valid_o/ex_ready_i issue handshake with dec_*_o fields; ex_done_i/ex_flag_i execute completion and flag;
// halted_o sticky self-jump indicator; retired_o saturating retire count; fetch_pc_o pc of the instruction in ir.
module fetch_sequencer #(
  parameter int unsigned     PC_W     = 9,
  parameter int unsigned     OP_W     = 23,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16,
  parameter logic [4:0]      OP_JMP   = 5'd16,
  parameter logic [4:0]      OP_JNZ   = 5'd17,
  parameter logic [4:0]      OP_ZNJ   = 5'd18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic [PC_W-1:0]  pc_o,
  input  logic [OP_W-1:0]  op_i,
  output logic             dec_valid_o,
  input  logic             ex_ready_i,
  input  logic             ex_done_i,
  input  logic             ex_flag_i,
  output logic [4:0]       dec_opcode_o,
  output logic [5:0]       dec_dst_o,
  output logic [5:0]       dec_src1_o,
  output logic [5:0]       dec_src2_o,
  output logic [4:0]       dec_imm_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o,
  output logic [PC_W-1:0]  fetch_pc_o
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT, HALT} state_t;
  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, fetch_pc_q, fetch_pc_d;
  logic [OP_W-1:0]   ir_q, ir_d, dec_q, dec_d;
  logic              flag_q, flag_d, dec_valid_q, dec_valid_d, halted_q, halted_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              is_br, taken, finish, retire;
  logic [4:0]        opc;
  logic [PC_W-1:0]   target;
  assign opc    = ir_q[22:18];
  assign target = ir_q[PC_W-1:0];
  assign is_br  = opc == OP_JMP || opc == OP_JNZ || opc == OP_ZNJ;
  assign taken  = opc == OP_JMP || (opc == OP_JNZ && flag_q) || (opc == OP_ZNJ && !flag_q);
  // execute completion: either same-cycle with the accept, or later while waiting
  assign finish = ex_done_i && ((state_q == ISSUE && ex_ready_i) || state_q == WAIT);
  assign retire = finish || (state_q == DECODE && is_br);
  assign retired_d = (retire && retired_q != '1) ? retired_q + 1'b1 : retired_q;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    fetch_pc_d  = fetch_pc_q;
    dec_d       = dec_q;
    dec_valid_d = dec_valid_q;
    flag_d      = flag_q;
    halted_d    = halted_q;
    case (state_q)
      IDLE:   state_d = start_i ? FETCH : IDLE;
      FETCH: begin
        ir_d       = op_i;
        fetch_pc_d = pc_q;
        state_d    = DECODE;
      end
      DECODE:
        if (!is_br) begin
          dec_d       = ir_q;
          dec_valid_d = 1'b1;
          state_d     = ISSUE;
        end else if (taken && target == fetch_pc_q) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          pc_d    = taken ? target : pc_q + 1'b1;
          state_d = FETCH;
        end
      ISSUE:
        if (ex_ready_i) begin
          dec_valid_d = 1'b0;
          state_d     = ex_done_i ? FETCH : WAIT;
        end
      WAIT:   state_d = ex_done_i ? FETCH : WAIT;
      default: state_d = HALT;
    endcase
    if (finish) begin
      flag_d = ex_flag_i;
      pc_d   = pc_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      fetch_pc_q  <= '0;
      dec_q       <= '0;
      dec_valid_q <= 1'b0;
      flag_q      <= 1'b0;
      halted_q    <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      fetch_pc_q  <= fetch_pc_d;
      dec_q       <= dec_d;
      dec_valid_q <= dec_valid_d;
      flag_q      <= flag_d;
      halted_q    <= halted_d;
      retired_q   <= retired_d;
    end
  assign pc_o         = pc_q;
  assign dec_valid_o  = dec_valid_q;
  assign dec_opcode_o = dec_q[22:18];
  assign dec_dst_o    = dec_q[17:12];
  assign dec_src1_o   = dec_q[11:6];
  assign dec_src2_o   = dec_q[5:0];
  assign dec_imm_o    = dec_q[4:0];
  assign halted_o     = halted_q;
  assign retired_o    = retired_q;
  assign fetch_pc_o   = fetch_pc_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed table, hand sequences and random programs against an instruction-level model
module tb_fetch_sequencer;
  localparam logic [4:0] JMP = 5'd16, JNZ = 5'd17, ZNJ = 5'd18, LI = 5'd1, ADD = 5'd2;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        ex_ready = 1'b0, ex_done = 1'b0, ex_flag = 1'b0;
  logic [22:0] imem [512];
  logic [22:0] op, op_s;
  logic [8:0]  pc, fetch_pc, pc_s, fetch_pc_s;
  logic        dec_valid, halted, dec_valid_s, halted_s;
  logic [4:0]  dec_opcode, dec_imm, dec_opcode_s, dec_imm_s;
  logic [5:0]  dec_dst, dec_src1, dec_src2, dec_dst_s, dec_src1_s, dec_src2_s;
  logic [15:0] retired;
  logic [1:0]  retired_s;
  int          checks = 0, errors = 0;
  int          m_pc, m_ret, wcnt, cyc;
  logic        m_flag, m_halt, busy;
  int unsigned r;
  always #5 clk = ~clk;
  assign op   = imem[pc];
  assign op_s = imem[pc_s];
  fetch_sequencer #(.PC_W(9), .OP_W(23), .RESET_PC(9'd0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .pc_o(pc), .op_i(op), .dec_valid_o(dec_valid),
    .ex_ready_i(ex_ready), .ex_done_i(ex_done), .ex_flag_i(ex_flag), .dec_opcode_o(dec_opcode),
    .dec_dst_o(dec_dst), .dec_src1_o(dec_src1), .dec_src2_o(dec_src2), .dec_imm_o(dec_imm),
    .halted_o(halted), .retired_o(retired), .fetch_pc_o(fetch_pc));
  fetch_sequencer #(.PC_W(9), .OP_W(23), .RESET_PC(9'd0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start_i(start), .pc_o(pc_s), .op_i(op_s), .dec_valid_o(dec_valid_s),
    .ex_ready_i(ex_ready), .ex_done_i(ex_done), .ex_flag_i(ex_flag), .dec_opcode_o(dec_opcode_s),
    .dec_dst_o(dec_dst_s), .dec_src1_o(dec_src1_s), .dec_src2_o(dec_src2_s), .dec_imm_o(dec_imm_s),
    .halted_o(halted_s), .retired_o(retired_s), .fetch_pc_o(fetch_pc_s));
  typedef struct {
    logic [4:0]  opc;
    logic        flag;
    logic [8:0]  tgt;
    logic [8:0]  pc;
    logic        halt;
    logic [15:0] ret;
    logic        dv;
  } vec_t;
  vec_t tbl [9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string nm);
    chk({nm, "_pc"}, 32'(pc), 32'd0);
    chk({nm, "_dv"}, 32'(dec_valid), 32'd0);
    chk({nm, "_halted"}, 32'(halted), 32'd0);
    chk({nm, "_retired"}, 32'(retired), 32'd0);
    chk({nm, "_fetch_pc"}, 32'(fetch_pc), 32'd0);
    chk({nm, "_dec"}, 32'({dec_opcode, dec_dst, dec_src1, dec_src2}), 32'd0);
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    start = 1'b0;
    ex_ready = 1'b0;
    ex_done = 1'b0;
    ex_flag = 1'b0;
    for (int i = 0; i < 512; i++) imem[i] = {JMP, 9'd0, 9'(i)};
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  // Architectural model: resolve branches at instruction granularity until a non-branch or halt
  task automatic walk();
    logic [22:0] w;
    logic        tk;
    for (int k = 0; k < 600 && !m_halt; k++) begin
      w = imem[m_pc];
      if (w[22:18] != JMP && w[22:18] != JNZ && w[22:18] != ZNJ) break;
      tk = w[22:18] == JMP || (w[22:18] == JNZ && m_flag) || (w[22:18] == ZNJ && !m_flag);
      m_ret++;
      if (tk && int'(w[8:0]) == m_pc) m_halt = 1'b1;
      else m_pc = tk ? int'(w[8:0]) : (m_pc + 1) % 512;
    end
  endtask
  initial begin
    tbl[0] = '{JNZ, 1'b1, 9'd80,  9'd80,  1'b0, 16'd2, 1'b0};
    tbl[1] = '{JNZ, 1'b0, 9'd80,  9'd2,   1'b0, 16'd2, 1'b0};
    tbl[2] = '{ZNJ, 1'b1, 9'd80,  9'd2,   1'b0, 16'd2, 1'b0};
    tbl[3] = '{ZNJ, 1'b0, 9'd80,  9'd80,  1'b0, 16'd2, 1'b0};
    tbl[4] = '{JMP, 1'b0, 9'd168, 9'd168, 1'b0, 16'd2, 1'b0};
    tbl[5] = '{JMP, 1'b1, 9'd1,   9'd1,   1'b1, 16'd2, 1'b0};
    tbl[6] = '{JNZ, 1'b0, 9'd1,   9'd2,   1'b0, 16'd2, 1'b0};
    tbl[7] = '{ZNJ, 1'b0, 9'd1,   9'd1,   1'b1, 16'd2, 1'b0};
    tbl[8] = '{LI,  1'b1, 9'd1,   9'd1,   1'b0, 16'd1, 1'b1};
    // reset values and first issue
    reset_dut();
    chk_idle("reset");
    imem[0] = {LI, 6'd9, 6'd0, 6'd0};
    imem[1] = {ADD, 6'd5, 6'd7, 6'd11};
    ex_ready = 1'b1;
    ex_done = 1'b1;
    pulse_start();
    chk("t1_dv_e0", 32'(dec_valid), 32'd0);
    tick();
    chk("t1_dv_e1", 32'(dec_valid), 32'd0);
    tick();
    chk("t1_dv_e2", 32'(dec_valid), 32'd1);
    chk("t1_fields", 32'({dec_opcode, dec_dst, dec_imm}), 32'({LI, 6'd9, 5'd0}));
    chk("t1_fetch_pc", 32'(fetch_pc), 32'd0);
    chk("t1_pc_hold", 32'(pc), 32'd0);
    tick();
    chk("t1_dv_e3", 32'(dec_valid), 32'd0);
    chk("t1_pc", 32'(pc), 32'd1);
    chk("t1_retired", 32'(retired), 32'd1);
    // stalled handshake then delayed completion with flag=1
    ex_ready = 1'b0;
    ex_done = 1'b0;
    tick();
    tick();
    chk("t2_dv", 32'(dec_valid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_stall_dv", 32'(dec_valid), 32'd1);
      chk("t2_stall_fields", 32'({dec_opcode, dec_dst, dec_src1, dec_src2}), 32'({ADD, 6'd5, 6'd7, 6'd11}));
      chk("t2_stall_pc", 32'(pc), 32'd1);
    end
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    chk("t2_accept_dv", 32'(dec_valid), 32'd0);
    chk("t2_accept_dst", 32'(dec_dst), 32'd5);
    chk("t2_accept_pc", 32'(pc), 32'd1);
    tick();
    chk("t2_wait_pc", 32'(pc), 32'd1);
    ex_done = 1'b1;
    ex_flag = 1'b1;
    imem[2] = {JNZ, 9'd0, 9'd168};
    tick();
    ex_done = 1'b0;
    ex_flag = 1'b0;
    chk("t2_done_pc", 32'(pc), 32'd2);
    chk("t2_done_retired", 32'(retired), 32'd2);
    tick();
    tick();
    chk("t3_jnz_pc", 32'(pc), 32'd168);
    chk("t3_jnz_dv", 32'(dec_valid), 32'd0);
    tick();
    tick();
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_retired", 32'(retired), 32'd4);
    for (int k = 0; k < 20; k++) begin
      start = k == 7;
      tick();
      chk("t4_halt_pc", 32'(pc), 32'd168);
      chk("t4_halt_dv", 32'(dec_valid), 32'd0);
    end
    start = 1'b0;
    chk("t4_halt_retired", 32'(retired), 32'd4);
    // branch decision table
    for (int i = 0; i < 9; i++) begin
      reset_dut();
      imem[0] = {LI, 6'd3, 6'd0, 6'd0};
      imem[1] = {tbl[i].opc, 9'h1a5, tbl[i].tgt};
      ex_ready = 1'b1;
      ex_done = 1'b1;
      ex_flag = tbl[i].flag;
      pulse_start();
      repeat (3) tick();
      chk("tbl_pc_e3", 32'(pc), 32'd1);
      tick();
      chk("tbl_dv_e4", 32'(dec_valid), 32'd0);
      tick();
      chk("tbl_pc", 32'(pc), 32'(tbl[i].pc));
      chk("tbl_halted", 32'(halted), 32'(tbl[i].halt));
      chk("tbl_retired", 32'(retired), 32'(tbl[i].ret));
      chk("tbl_dv", 32'(dec_valid), 32'(tbl[i].dv));
    end
    // async reset while waiting on execute, then stray ex_done
    reset_dut();
    imem[0] = {JMP, 9'd0, 9'd45};
    imem[45] = {ADD, 6'd1, 6'd2, 6'd3};
    ex_ready = 1'b1;
    pulse_start();
    repeat (5) tick();
    chk("t5_wait_pc", 32'(pc), 32'd45);
    chk("t5_wait_retired", 32'(retired), 32'd1);
    chk("t5_wait_dv", 32'(dec_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_idle("t5_async");
    @(negedge clk);
    rst_n = 1'b1;
    ex_done = 1'b1;
    ex_flag = 1'b1;
    repeat (3) tick();
    chk("t5_stray_retired", 32'(retired), 32'd0);
    chk("t5_stray_pc", 32'(pc), 32'd0);
    ex_done = 1'b0;
    ex_flag = 1'b0;
    imem[0] = {JNZ, 9'd0, 9'd80};
    pulse_start();
    tick();
    tick();
    chk("t5_flag_clear_pc", 32'(pc), 32'd1);
    chk("t5_flag_clear_retired", 32'(retired), 32'd1);
    // pc wrap and counter saturation
    reset_dut();
    imem[0] = {JMP, 9'd0, 9'd511};
    imem[511] = {LI, 6'd2, 6'd0, 6'd7};
    ex_ready = 1'b1;
    ex_done = 1'b1;
    pulse_start();
    tick();
    tick();
    chk("t6_pc511", 32'(pc), 32'd511);
    repeat (3) tick();
    chk("t6_wrap_pc", 32'(pc), 32'd0);
    chk("t6_wrap_retired", 32'(retired), 32'd2);
    repeat (5) tick();
    chk("t6_retired4", 32'(retired), 32'd4);
    chk("t6_sat_retired", 32'(retired_s), 32'd3);
    // random forward-only programs with random execute timing
    for (int p = 0; p < 15; p++) begin
      reset_dut();
      for (int i = 0; i < 64; i++) begin
        r = $urandom_range(0, 9);
        if (r < 4) imem[i] = {5'(16 + $urandom_range(0, 2)), 9'($urandom), 9'(i + $urandom_range(0, 6))};
        else imem[i] = {5'($urandom_range(0, 15)), 18'($urandom)};
      end
      m_pc = 0;
      m_ret = 0;
      m_flag = 1'b0;
      m_halt = 1'b0;
      busy = 1'b0;
      wcnt = 0;
      pulse_start();
      for (cyc = 0; cyc < 3000 && !halted; cyc++) begin
        @(negedge clk);
        ex_flag = 1'($urandom);
        if (busy) begin
          ex_ready = 1'($urandom);
          ex_done = wcnt == 0;
          if (ex_done) begin
            m_flag = ex_flag;
            m_pc = (m_pc + 1) % 512;
            m_ret++;
            busy = 1'b0;
          end else wcnt--;
        end else if (dec_valid) begin
          ex_ready = $urandom_range(0, 2) != 0;
          ex_done = ex_ready && 1'($urandom);
          if (ex_ready) begin
            walk();
            chk("rnd_fields", 32'({dec_opcode, dec_dst, dec_src1, dec_src2}), 32'(imem[m_pc]));
            chk("rnd_pc", 32'(pc), 32'(m_pc));
            chk("rnd_fetch_pc", 32'(fetch_pc), 32'(m_pc));
            chk("rnd_retired", 32'(retired), 32'(m_ret));
            chk("rnd_sat", 32'(retired_s), 32'((m_ret > 3) ? 3 : m_ret));
            if (ex_done) begin
              m_flag = ex_flag;
              m_pc = (m_pc + 1) % 512;
              m_ret++;
            end else begin
              busy = 1'b1;
              wcnt = $urandom_range(0, 3);
            end
          end
        end else begin
          ex_ready = 1'($urandom);
          ex_done = $urandom_range(0, 5) == 0;
        end
      end
      ex_done = 1'b0;
      chk("rnd_terminated", 32'(halted), 32'd1);
      walk();
      chk("rnd_final_halt", 32'(m_halt), 32'd1);
      chk("rnd_final_pc", 32'(pc), 32'(m_pc));
      chk("rnd_final_retired", 32'(retired), 32'(m_ret));
      chk("rnd_final_sat", 32'(retired_s), 32'((m_ret > 3) ? 3 : m_ret));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction fetch/sequencing front end that reads the 23-bit instruction ROM (imem) for the puzzle-solver datapath.
- Drives the 9-bit pc, captures the returned op and splits it into fields.
- Resolves JMP/JNZ/ZNJ internally against a flag latched from the execute unit.
- Issues all other instructions to execute over a valid/ready handshake, one instruction in flight.
- Detects the terminal self-jump (halt) and counts retired instructions.

Parameters:
PC_W, 9, pc width; pc arithmetic wraps modulo 2^PC_W
OP_W, 23, instruction width
RESET_PC, 0, pc value loaded at reset
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; leaves IDLE and begins fetching at pc
pc  out  PC_W  instruction address to imem
op  in  OP_W  instruction from imem; combinational in pc, valid in the same cycle
dec_valid  out  1  decoded instruction presented to execute
ex_ready  in  1  execute accepts the instruction when dec_valid&&ex_ready
ex_done  in  1  execute finished the accepted instruction; ex_flag valid this cycle
ex_flag  in  1  result flag (nonzero) of the finished instruction
dec_opcode  out  5  op[22:18]
dec_dst  out  6  op[17:12]
dec_src1  out  6  op[11:6]
dec_src2  out  6  op[5:0]
dec_imm  out  5  op[4:0]
halted  out  1  sticky; set on self-jump
retired  out  CNT_W  count of completed instructions (branches included), saturating
fetch_pc  out  PC_W  pc of the instruction currently in ir (debug)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=0, flag_q=0, dec_valid=0, all dec_* outputs=0, halted=0, retired=0, fetch_pc=0. Reset asserted mid-operation aborts any in-flight instruction immediately; a later ex_done is ignored because state is IDLE.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT, HALT.
- IDLE: wait for start=1, then go to FETCH.
- FETCH (1 cycle): ir<=op, fetch_pc<=pc; go to DECODE.
- DECODE (1 cycle): the opcode compares against the def.h constants JMP, JNZ, ZNJ. target=ir[8:0].
  - JMP: taken.
  - JNZ: taken iff flag_q=1.
  - ZNJ: taken iff flag_q=0.
  - Taken branch with target==fetch_pc: halted<=1, retired+1, go to HALT; pc unchanged.
  - Taken branch otherwise: pc<=target, retired+1, go to FETCH.
  - Not-taken branch: pc<=pc+1, retired+1, go to FETCH.
  - Branch latency is therefore 2 cycles per branch, with no issue to execute.
  - Non-branch: register the dec_* fields from ir, dec_valid<=1, go to ISSUE.
- ISSUE: dec_valid=1 and dec_* are held stable until ex_ready=1.
  - On accept: dec_valid<=0.
  - If ex_done=1 in the same cycle (single-cycle execute): flag_q<=ex_flag, pc<=pc+1, retired+1, go to FETCH.
  - Otherwise go to WAIT.
- WAIT: hold until ex_done=1; then flag_q<=ex_flag, pc<=pc+1, retired+1, go to FETCH.
- ex_done outside ISSUE-accept and WAIT is ignored; flag_q is unaffected.
- HALT: absorbing; dec_valid=0, pc frozen. Only reset exits. start is ignored.
- start in any state other than IDLE is ignored.
- pc+1 wraps 511->0 silently.
- retired saturates at 2^CNT_W-1.
- dec_* outputs keep their last values after accept (not cleared); consumers qualify with dec_valid.
- Non-branch instruction throughput: 3 cycles minimum (FETCH, DECODE, ISSUE with ex_ready=ex_done=1).

Test Plan:
1. Reset, then start; imem op=LI dst 9 imm 0 at pc 0, ex_ready=ex_done=1 → dec_valid high exactly 1 cycle, 3 cycles after start; dec_opcode=LI, dec_dst=9, dec_imm=0; pc=1 next; retired=1.
2. Execute stalls ex_ready=0 for 4 cycles, then 1; ex_done 2 cycles later with ex_flag=1 → dec_* stable throughout; pc advances only after ex_done; flag_q=1.
3. JNZ target 80 with flag_q=1 → pc=80 two cycles after FETCH, no dec_valid. Same with flag_q=0 → pc=fetch_pc+1. ZNJ gives the inverse outcomes.
4. JMP target 168 at pc 168 → halted=1, pc stays 168, dec_valid stays 0 for 20 cycles; start pulse has no effect.
5. rst_n low while in WAIT at pc 45 → outputs return to reset values immediately; a stray ex_done afterward does not change retired or flag_q.
6. Sequential non-branch ops from pc 511 → pc wraps to 0. With CNT_W=2, retired holds at 3 after the 4th retire.
